// File: rtl/mux_arb_n.sv
// N-channel, W-bit registered multiplexer with valid/ready on every input and
// on the output. Arbitration is either directed (sel) or round-robin.
module mux_arb_n #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  lane [N];
  logic [W-1:0]  data_q;
  logic [SW-1:0] ch_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          take;
  logic          load;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

  // Split the flat input bus into per-channel lanes.
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      lane[k] = in_data[k*W +: W];
    end
  end

  // Grant selection: directed by sel, or round-robin starting after ptr.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    if (mode == 1'b0) begin
      if ((int'(sel) < int'(N)) && in_valid[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
      end
    end else begin
      // Walk from the farthest offset down so the nearest valid channel wins.
      for (int i = int'(N); i >= 1; i--) begin
        idx = (int'(ptr_q) + i) % int'(N);
        if (in_valid[idx[SW-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx[SW-1:0];
        end
      end
    end
  end

  // State register for the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: reload whenever the register can take, else hold.
  always_comb begin
    state_d = state_q;
    if (take) begin
      state_d = gnt_valid ? FULL : EMPTY;
    end
  end

  // Handshake outputs: one-hot ready on the granted channel, none in reset.
  always_comb begin
    take     = (state_q == EMPTY) | out_ready;
    load     = take & gnt_valid & ~rst;
    in_ready = '0;
    if (load) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // Output data, source channel and round-robin pointer update on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= SW'(N - 1);
    end else if (load) begin
      data_q <= lane[gnt_idx];
      ch_q   <= gnt_idx;
      ptr_q  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n (N=8, W=8): stimulus pushes expected words,
// a monitor pops and compares each word the DUT hands downstream.
module tb_mux_arb_n;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mux_arb_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [W-1:0] d, input logic [SW-1:0] ch);
    exp_t e;
    e.d  = d;
    e.ch = ch;
    sb_q.push_back(e);
  endtask

  // Check in_ready mid-cycle, then advance to just after the next edge.
  task automatic step(input logic [N-1:0] exp_rdy, input string nm);
    @(negedge clk);
    chk(nm, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every word consumed downstream must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got data 0x%0h ch %0d, expected none", out_data, out_ch);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_ch", 64'(out_ch), 64'(e.ch));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int exp4_ch [5] = '{4, 7, 4, 7, 4};
    int k;

    for (int c = 0; c < int'(N); c++) in_data[c*W +: W] = 8'(int'(8'hA2) + c);
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;

    // Reset state, with requests pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_ch", 64'(out_ch), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0; mode = 1'b0;

    // Directed select of channel 3.
    sel = 3'd3; in_valid = 8'h08;
    push(8'hA5, 3'd3);
    step(8'h08, "t1_rdy");
    in_valid = '0;
    step(8'h00, "t1_idle");

    // Directed select of an idle channel: nobody else is granted.
    sel = 3'd2; in_valid = 8'hFB;
    step(8'h00, "t2_rdy");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_out_valid", 64'(out_valid), 64'h0);
      chk("t2_rdy_hold", 64'(in_ready), 64'h0);
      @(posedge clk); #1;
    end

    // Reset pulse returns ptr to N-1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin with all channels valid: 0..7,0,1.
    mode = 1'b1; in_valid = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      k = i % 8;
      push(8'(int'(8'hA2) + k), SW'(k));
      step(8'(1 << k), "t3_rdy");
    end

    // Round-robin over channels 4 and 7 only (ptr=1 here, so 4 comes first).
    in_valid = 8'h90;
    for (int i = 0; i < 5; i++) begin
      k = exp4_ch[i];
      push(8'(int'(8'hA2) + k), SW'(k));
      step(8'(1 << k), "t4_rdy");
    end

    // Backpressure: hold channel 7's word for 3 cycles, then reload with no bubble.
    push(8'hA9, 3'd7);
    step(8'h80, "t5_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_rdy", 64'(in_ready), 64'h0);
      chk("t5_hold_valid", 64'(out_valid), 64'h1);
      chk("t5_hold_data", 64'(out_data), 64'hA9);
      chk("t5_hold_ch", 64'(out_ch), 64'h7);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push(8'hA6, 3'd4);
    step(8'h10, "t5_resume");
    in_valid = '0;
    @(negedge clk);
    chk("t5_no_bubble", 64'(out_valid), 64'h1);
    @(posedge clk); #1;

    // Reset while FULL with ptr=5: word discarded, channel 0 first afterwards.
    in_valid = 8'h20;
    push(8'hA7, 3'd5);
    step(8'h20, "t6_load");
    out_ready = 1'b0; in_valid = 8'hFF;
    @(negedge clk);
    #2;
    rst = 1'b1;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'h0);
    chk("t6_async_rdy", 64'(in_ready), 64'h0);
    chk("t6_async_data", 64'(out_data), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    push(8'hA2, 3'd0);
    step(8'h01, "t6_first");
    in_valid = '0;
    step(8'h00, "t6_idle");
    step(8'h00, "t6_drain");
    chk("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It is the next generation of the team's fixed 8:1 bit mux, generalised in channel count and data width. It adds a registered output stage, backpressure, and a selectable round-robin arbitration mode. It sits between several producer channels and one shared downstream consumer.

## Interface
- N, default 8: number of input channels, legal range 2..16.
- W, default 8: data width per channel, legal range 1..64.
- SW (localparam) = $clog2(N): width of the channel index.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  selects the arbitration mode: 0 = directed select, 1 = round-robin.
- sel  in  SW  channel index, used in mode 0 only.
- in_data  in  N*W  channel k occupies bits [k*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit is high in any cycle.
- out_data  out  W  registered data.
- out_ch  out  SW  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  downstream accepts the output.

## Operation
- The output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- take = !out_valid | out_ready. The register may load in any cycle where take=1.
- Grant selection, computed combinationally each cycle:
  - mode 0: the grant goes to sel when sel < N and in_valid[sel]=1. Otherwise there is no grant. Requests on other channels are ignored.
  - mode 1: scan channels starting at ptr+1 (mod N) and wrapping. The grant goes to the first k found with in_valid[k]=1. If no bit of in_valid is set, there is no grant.
- in_ready[g] = take & grant_valid & (k==g). Every other in_ready bit is 0.
- Transfer on channel g happens when in_valid[g] & in_ready[g]. At the next edge:
  - out_data <= in_data[g*W +: W]
  - out_ch <= g
  - out_valid <= 1
  - ptr <= g
- If take=1 and there is no grant: out_valid <= 0. out_data and out_ch hold their values.
- If take=0 (FULL and out_ready=0): all outputs hold and all in_ready bits are 0.
- ptr updates on a transfer in either mode. Changing mode does not reset ptr.
- A change on mode or sel affects only the grant in the cycle in which it is sampled. Data already in the output register is unaffected.
- sel ≥ N (possible only when N is not a power of 2): no grant, and in_ready stays at 0.

## Timing
- Reset values while rst=1, applied asynchronously:
  - out_valid=0, out_data=0, out_ch=0.
  - ptr=N-1, so channel 0 has first priority after reset.
  - in_ready is forced to all zeros.
- Latency: 1 cycle from the transfer edge to out_valid/out_data.
- Throughput: 1 transfer per cycle while out_ready=1 and a grant exists.
- Backpressure: when FULL and out_ready=0, accepting input takes 0 cycles once out_ready rises. The register reloads on the same edge as the downstream consumption, so the output never has a bubble.
- Asserting rst mid-transfer discards the held word. in_ready drops immediately, so no handshake completes on that edge.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, the grants follow 0,1,…,N-1,0 in consecutive cycles.

## Test plan
- Reset, then mode 0, sel=3, in_valid=8'h08, channel 3 data=8'hA5, out_ready=1 -> in_ready=8'h08 in the same cycle. Next cycle: out_valid=1, out_data=8'hA5, out_ch=3.
- Mode 0, sel=2, in_valid=8'hFB (bit 2 clear) -> in_ready=0. After the register drains, out_valid=0 and the other channels are never granted.
- Mode 1, in_valid=8'hFF, out_ready=1 for 10 cycles -> out_ch sequence is 0,1,2,3,4,5,6,7,0,1 with one word per cycle.
- Mode 1, in_valid=8'h90 (channels 4 and 7), ptr=4 -> the grant goes to 7, then 4, then 7, alternating.
- FULL with out_ready=0 for 3 cycles -> out_data and out_ch are stable, in_ready=0. Raising out_ready consumes the held word and loads the next word on the same edge.
- rst pulsed while FULL, mode 1, ptr=5 -> out_valid=0 and in_ready=0 asynchronously. After release, the first grant with in_valid=8'hFF goes to channel 0.
